ddr3_app_arbiter: RTL and testbench



---
 rtl/ddr3_app_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_ddr3_app_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_app_arbiter.sv
// ddr3_app_arbiter: two-requester (write/read) command arbiter in front of a
// DDR3 MIG user interface. One command is in flight at a time: IDLE picks a
// requester and registers the MIG command; ISSUE holds it until app_rdy, then
// acknowledges the winner with a one-cycle combinational pulse.
// Acquisition mode gives writes strict priority; otherwise a round-robin with
// a run limit of MAX_RUN grants applies.
// Optional feature macro: DDR3_APP_ARB_STATS_EN (command/stall statistics).
module ddr3_app_arbiter #(
  parameter int MAX_RUN = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_calib_complete,
  input  logic        acq_enabled,
  input  logic        wr_app_en,
  input  logic [25:0] wr_addr,
  output logic        wr_app_rdy,
  input  logic        rd_app_en,
  input  logic [25:0] rd_addr,
  output logic        rd_app_rdy,
  output logic [26:0] app_addr,
  output logic [2:0]  app_cmd,
  output logic        app_en,
  input  logic        app_rdy,
  output logic [31:0] wr_cmd_cnt,
  output logic [31:0] rd_cmd_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  localparam logic [7:0] MAX_RUN_C = 8'(MAX_RUN);
  localparam logic [2:0] CMD_WR    = 3'b000;
  localparam logic [2:0] CMD_RD    = 3'b001;

  state_t      state_q, state_d;
  logic        app_en_q, app_en_d;
  logic [26:0] app_addr_q, app_addr_d;
  logic [2:0]  app_cmd_q, app_cmd_d;
  logic        gnt_wr_q, gnt_wr_d;     // requester owning the in-flight command
  logic        last_wr_q, last_wr_d;   // requester granted most recently
  logic [7:0]  run_cnt_q, run_cnt_d;
  logic        armed_q;                // blocks grants on the first edge after reset

  logic        pick_wr_s;
  logic        req_any_s;
  logic        accept_s;
  logic        wr_ack_s;
  logic        rd_ack_s;

  assign req_any_s = wr_app_en | rd_app_en;
  assign accept_s  = (state_q == ST_ISSUE) & app_rdy;

  // Choose the requester that would win if a grant is made this cycle.
  always_comb begin
    pick_wr_s = 1'b1;
    if (wr_app_en && rd_app_en) begin
      if (acq_enabled) begin
        pick_wr_s = 1'b1;
      end else if (run_cnt_q >= MAX_RUN_C) begin
        pick_wr_s = ~last_wr_q;
      end else begin
        pick_wr_s = last_wr_q;
      end
    end else begin
      pick_wr_s = wr_app_en;
    end
  end

  // Next-state, command register and acknowledge logic of the issue FSM.
  always_comb begin
    state_d    = state_q;
    app_en_d   = app_en_q;
    app_addr_d = app_addr_q;
    app_cmd_d  = app_cmd_q;
    gnt_wr_d   = gnt_wr_q;
    last_wr_d  = last_wr_q;
    run_cnt_d  = run_cnt_q;
    wr_ack_s   = 1'b0;
    rd_ack_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && init_calib_complete && req_any_s) begin
          state_d    = ST_ISSUE;
          app_en_d   = 1'b1;
          gnt_wr_d   = pick_wr_s;
          app_addr_d = pick_wr_s ? {1'b0, wr_addr} : {1'b0, rd_addr};
          app_cmd_d  = pick_wr_s ? CMD_WR : CMD_RD;
        end else begin
          app_en_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (app_rdy) begin
          wr_ack_s  = gnt_wr_q;
          rd_ack_s  = ~gnt_wr_q;
          state_d   = ST_IDLE;
          app_en_d  = 1'b0;
          last_wr_d = gnt_wr_q;
          if (gnt_wr_q == last_wr_q) begin
            run_cnt_d = (run_cnt_q >= MAX_RUN_C) ? MAX_RUN_C : (run_cnt_q + 8'd1);
          end else begin
            run_cnt_d = 8'd1;
          end
        end else begin
          app_en_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        app_en_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered MIG command outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      app_en_q   <= 1'b0;
      app_addr_q <= 27'd0;
      app_cmd_q  <= 3'b000;
      gnt_wr_q   <= 1'b1;
      last_wr_q  <= 1'b1;
      run_cnt_q  <= 8'd0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      app_en_q   <= app_en_d;
      app_addr_q <= app_addr_d;
      app_cmd_q  <= app_cmd_d;
      gnt_wr_q   <= gnt_wr_d;
      last_wr_q  <= last_wr_d;
      run_cnt_q  <= run_cnt_d;
      armed_q    <= 1'b1;
    end
  end

  assign app_en     = app_en_q;
  assign app_addr   = app_addr_q;
  assign app_cmd    = app_cmd_q;
  assign wr_app_rdy = wr_ack_s;
  assign rd_app_rdy = rd_ack_s;

`ifdef DDR3_APP_ARB_STATS_EN
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] stall_q, stall_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  // Saturating statistics: accepted writes/reads and back-pressure cycles.
  always_comb begin
    wr_cnt_d = sat_inc32(wr_cnt_q, accept_s & gnt_wr_q);
    rd_cnt_d = sat_inc32(rd_cnt_q, accept_s & ~gnt_wr_q);
    stall_d  = sat_inc32(stall_q, app_en_q & ~app_rdy);
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q <= 32'd0;
      rd_cnt_q <= 32'd0;
      stall_q  <= 32'd0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      stall_q  <= stall_d;
    end
  end

  assign wr_cmd_cnt = wr_cnt_q;
  assign rd_cmd_cnt = rd_cnt_q;
  assign stall_cnt  = stall_q;
`else
  assign wr_cmd_cnt = 32'd0;
  assign rd_cmd_cnt = 32'd0;
  assign stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Self-checking bench for ddr3_app_arbiter: table of single-grant vectors,
// then hand-written sequences for priority, round-robin, stall, calibration
// gating and reset-in-flight. Acknowledged commands are compared against a
// queue of expected commands filled when stimulus is applied.
module tb_ddr3_app_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        init_calib_complete = 1'b0;
  logic        acq_enabled = 1'b0;
  logic        wr_app_en = 1'b0;
  logic [25:0] wr_addr = 26'd0;
  logic        wr_app_rdy;
  logic        rd_app_en = 1'b0;
  logic [25:0] rd_addr = 26'd0;
  logic        rd_app_rdy;
  logic [26:0] app_addr;
  logic [2:0]  app_cmd;
  logic        app_en;
  logic        app_rdy = 1'b0;
  logic [31:0] wr_cmd_cnt;
  logic [31:0] rd_cmd_cnt;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  ddr3_app_arbiter #(.MAX_RUN(8)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .init_calib_complete (init_calib_complete),
    .acq_enabled         (acq_enabled),
    .wr_app_en           (wr_app_en),
    .wr_addr             (wr_addr),
    .wr_app_rdy          (wr_app_rdy),
    .rd_app_en           (rd_app_en),
    .rd_addr             (rd_addr),
    .rd_app_rdy          (rd_app_rdy),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .wr_cmd_cnt          (wr_cmd_cnt),
    .rd_cmd_cnt          (rd_cmd_cnt),
    .stall_cnt           (stall_cnt)
  );

`ifdef DDR3_APP_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic        is_wr;
    logic [26:0] addr;
    logic [2:0]  cmd;
  } exp_t;

  typedef struct {
    logic        acq;
    logic        wr_en;
    logic        rd_en;
    logic [25:0] wa;
    logic [25:0] ra;
    logic        exp_wr;
    logic [26:0] exp_addr;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   acks_seen = 0;
  logic smp_wr_ack;
  logic smp_rd_ack;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_wr, input logic [26:0] addr);
    exp_t e;
    e.is_wr = is_wr;
    e.addr  = addr;
    e.cmd   = is_wr ? 3'b000 : 3'b001;
    sb_q.push_back(e);
  endtask

  // Sample one cycle at the falling edge, score any ack, return just after the next rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    smp_wr_ack = wr_app_rdy;
    smp_rd_ack = rd_app_rdy;
    if (smp_wr_ack & smp_rd_ack) begin
      checks++;
      errors++;
      $display("FAIL ack_exclusive wr=%0b rd=%0b required one-hot", smp_wr_ack, smp_rd_ack);
    end
    if (smp_wr_ack | smp_rd_ack) begin
      acks_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack wr=%0b rd=%0b addr=%0h required none", smp_wr_ack, smp_rd_ack, app_addr);
      end else begin
        e = sb_q.pop_front();
        chk("ack_is_wr", 64'(smp_wr_ack), 64'(e.is_wr));
        chk("ack_addr", 64'(app_addr), 64'(e.addr));
        chk("ack_cmd", 64'(app_cmd), 64'(e.cmd));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (acks_seen < target && n < budget) begin
      cyc();
      n++;
    end
    chk("ack_budget", 64'(acks_seen), 64'(target));
  endtask

  task automatic do_reset();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int target;
    vecs[0] = '{1'b1, 1'b1, 1'b0, 26'h0000123, 26'h0000000, 1'b1, 27'h0000123};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 26'h0000000, 26'h0000456, 1'b0, 27'h0000456};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 26'h0000010, 26'h0000020, 1'b1, 27'h0000010};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 26'h0000030, 26'h0000040, 1'b1, 27'h0000030};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 26'h0000000, 26'h3FFFFFF, 1'b0, 27'h3FFFFFF};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 26'h3FFFFFF, 26'h0000000, 1'b1, 27'h3FFFFFF};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 26'h2AAAAAA, 26'h1555555, 1'b1, 27'h2AAAAAA};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 26'h0000000, 26'h0000000, 1'b0, 27'h0000000};

    // Reset state, asserted before any clock edge.
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_app_en", 64'(app_en), 64'd0);
    chk("rst_app_cmd", 64'(app_cmd), 64'd0);
    chk("rst_app_addr", 64'(app_addr), 64'd0);
    chk("rst_wr_ack", 64'(wr_app_rdy), 64'd0);
    chk("rst_rd_ack", 64'(rd_app_rdy), 64'd0);
    chk("rst_wr_cnt", 64'(wr_cmd_cnt), 64'd0);
    chk("rst_rd_cnt", 64'(rd_cmd_cnt), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc();

    // Table: one grant from a fresh reset per vector.
    for (int i = 0; i < 8; i++) begin
      acq_enabled = vecs[i].acq;
      wr_app_en = vecs[i].wr_en;
      rd_app_en = vecs[i].rd_en;
      wr_addr = vecs[i].wa;
      rd_addr = vecs[i].ra;
      init_calib_complete = 1'b1;
      app_rdy = 1'b1;
      do_reset();
      push_exp(vecs[i].exp_wr, vecs[i].exp_addr);
      target = acks_seen + 1;
      cyc();
      cyc();
      chk("vec_app_en", 64'(app_en), 64'd1);
      chk("vec_app_addr", 64'(app_addr), 64'(vecs[i].exp_addr));
      chk("vec_app_cmd", 64'(app_cmd), vecs[i].exp_wr ? 64'd0 : 64'd1);
      wait_acks(target, 10);
      wr_app_en = 1'b0;
      rd_app_en = 1'b0;
      cyc();
      chk("vec_idle_en", 64'(app_en), 64'd0);
    end

    // Acquisition mode, both pending: writes only, every second cycle.
    acq_enabled = 1'b1;
    wr_app_en = 1'b1;
    rd_app_en = 1'b1;
    wr_addr = 26'h0000010;
    rd_addr = 26'h0000020;
    do_reset();
    for (int k = 0; k < 5; k++) push_exp(1'b1, 27'h0000010);
    for (int k = 0; k < 11; k++) begin
      cyc();
      chk("acq_wr_ack", 64'(smp_wr_ack), 64'((k >= 2) && (k % 2 == 0)));
      chk("acq_rd_ack", 64'(smp_rd_ack), 64'd0);
    end
    wr_app_en = 1'b0;
    rd_app_en = 1'b0;
    cyc();
    chk("acq_end_en", 64'(app_en), 64'd0);

    // Round-robin, both pending: 8 writes, 8 reads, repeated.
    acq_enabled = 1'b0;
    wr_app_en = 1'b1;
    rd_app_en = 1'b1;
    wr_addr = 26'h0000100;
    rd_addr = 26'h0000200;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) begin
        if (r % 2 == 0) push_exp(1'b1, 27'h0000100);
        else push_exp(1'b0, 27'h0000200);
      end
    end
    wait_acks(acks_seen + 32, 200);
    wr_app_en = 1'b0;
    rd_app_en = 1'b0;
    cyc();
    chk("rr_wr_cnt", 64'(wr_cmd_cnt), STATS ? 64'd16 : 64'd0);
    chk("rr_rd_cnt", 64'(rd_cmd_cnt), STATS ? 64'd16 : 64'd0);

    // Read stalled 5 cycles by app_rdy=0; inputs change mid-command.
    acq_enabled = 1'b0;
    app_rdy = 1'b0;
    do_reset();
    cyc();
    cyc();
    rd_app_en = 1'b1;
    rd_addr = 26'h0000155;
    cyc();
    chk("stall_app_en", 64'(app_en), 64'd1);
    chk("stall_cmd", 64'(app_cmd), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        rd_app_en = 1'b0;
        init_calib_complete = 1'b0;
        acq_enabled = 1'b1;
      end
      cyc();
      chk("stall_hold_en", 64'(app_en), 64'd1);
      chk("stall_hold_addr", 64'(app_addr), 64'h155);
      chk("stall_no_ack", 64'(smp_rd_ack), 64'd0);
    end
    app_rdy = 1'b1;
    push_exp(1'b0, 27'h0000155);
    cyc();
    chk("stall_rd_ack", 64'(smp_rd_ack), 64'd1);
    chk("stall_done_en", 64'(app_en), 64'd0);
    chk("stall_cnt", 64'(stall_cnt), STATS ? 64'd5 : 64'd0);
    chk("stall_rd_cnt", 64'(rd_cmd_cnt), STATS ? 64'd1 : 64'd0);

    // No grants before calibration; app_en follows one cycle after it rises.
    init_calib_complete = 1'b0;
    acq_enabled = 1'b1;
    wr_app_en = 1'b1;
    rd_app_en = 1'b1;
    wr_addr = 26'h0000077;
    app_rdy = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("calib_low_en", 64'(app_en), 64'd0);
    end
    init_calib_complete = 1'b1;
    #1;
    chk("calib_rise_en", 64'(app_en), 64'd0);
    push_exp(1'b1, 27'h0000077);
    target = acks_seen + 1;
    cyc();
    chk("calib_next_en", 64'(app_en), 64'd1);
    wr_app_en = 1'b0;
    rd_app_en = 1'b0;
    cyc();
    chk("calib_acks", 64'(acks_seen), 64'(target));

    // Reset mid-ISSUE drops the command; request reissued on 2nd edge after release.
    acq_enabled = 1'b1;
    wr_app_en = 1'b1;
    wr_addr = 26'h000002C;
    app_rdy = 1'b0;
    do_reset();
    cyc();
    cyc();
    chk("rst_issue_en", 64'(app_en), 64'd1);
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_en", 64'(app_en), 64'd0);
    chk("rst_mid_addr", 64'(app_addr), 64'd0);
    app_rdy = 1'b1;
    #1;
    chk("rst_mid_wr_ack", 64'(wr_app_rdy), 64'd0);
    chk("rst_mid_rd_ack", 64'(rd_app_rdy), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_en", 64'(app_en), 64'd0);
    reset_n = 1'b1;
    cyc();
    chk("rst_first_edge_en", 64'(app_en), 64'd0);
    push_exp(1'b1, 27'h000002C);
    target = acks_seen + 1;
    cyc();
    chk("rst_second_edge_en", 64'(app_en), 64'd1);
    wr_app_en = 1'b0;
    cyc();
    chk("rst_reissue_acks", 64'(acks_seen), 64'(target));

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
